// File: rtl/pim_mac_engine_pkg.sv
// -----------------------------------------------------------------------------
// pim_mac_engine_pkg
// Shared types and sizing for the PIM MAC engine.
//   WIDTH            element width in bits
//   MATRIX_SIZE      inner dimension M of the chunk product
//   CHUNK_SIZE       tile edge C
//   NUM_OF_PIM_UNITS number of engine instances behind one controller
//   mac_state_t      engine FSM states
//   cnt_width()      counter width for a given range, never below 1 bit
// -----------------------------------------------------------------------------
package pim_mac_engine_pkg;

    localparam int WIDTH            = 16;
    localparam int MATRIX_SIZE      = 4;
    localparam int CHUNK_SIZE       = 2;
    localparam int NUM_OF_PIM_UNITS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mac_state_t;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pim_mac_engine_mac.sv
// -----------------------------------------------------------------------------
// pim_mac
// Combinational multiply-add: o_sum = i_acc + trunc_WIDTH(i_a * i_b).
// Unsigned arithmetic. Default build wraps modulo 2^WIDTH; with the macro
// PIM_MAC_SATURATE_EN defined the addition clamps to 2^WIDTH-1 on carry-out.
// The product is truncated to WIDTH bits in both builds.
// Ports:
//   i_acc  in  WIDTH  running accumulator
//   i_a    in  WIDTH  A operand element
//   i_b    in  WIDTH  B operand element
//   o_sum  out WIDTH  updated accumulator value
// -----------------------------------------------------------------------------
module pim_mac #(
    parameter int WIDTH = pim_mac_engine_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] w_prod;

    // Assignment context is WIDTH bits, so the product is truncated here.
    assign w_prod = i_a * i_b;

`ifdef PIM_MAC_SATURATE_EN
    logic [WIDTH:0] w_sum_ext;

    assign w_sum_ext = {1'b0, i_acc} + {1'b0, w_prod};
    // A carry out of WIDTH bits pins the element at full scale; once there,
    // any further non-zero product carries again, so it stays pinned.
    assign o_sum     = w_sum_ext[WIDTH] ? {WIDTH{1'b1}} : w_sum_ext[WIDTH-1:0];
`else
    assign o_sum = i_acc + w_prod;
`endif

endmodule

// File: rtl/pim_mac_engine.sv
// -----------------------------------------------------------------------------
// pim_mac_engine
// Responder-side compute engine of a PIM unit slot. On a valid request in
// IDLE it captures a CxM row-chunk of A and an MxC column-chunk of B, then
// computes the CxC tile with one MAC per cycle (C*C*M cycles), and holds the
// tile with result_valid high until valid is released.
// Build option: PIM_MAC_SATURATE_EN selects saturating accumulation.
// Ports:
//   clk           in   sole clock, posedge
//   rst           in   synchronous active-low reset
//   valid         in   level request; sampled in IDLE, released in DONE
//   matrixA       in   C*M elements, element [row][k] at index row*M+k
//   matrixB       in   M*C elements, element [k][col] at index k*C+col
//   result        out  C*C elements, element (r,c) at index r*C+c
//   result_valid  out  high while a completed tile is held (DONE)
//   busy          out  high in COMPUTE
// -----------------------------------------------------------------------------
module pim_mac_engine
    import pim_mac_engine_pkg::*;
#(
    parameter int ID          = 0,
    parameter int WIDTH       = pim_mac_engine_pkg::WIDTH,
    parameter int MATRIX_SIZE = pim_mac_engine_pkg::MATRIX_SIZE,
    parameter int CHUNK_SIZE  = pim_mac_engine_pkg::CHUNK_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     valid,
    input  logic [CHUNK_SIZE*MATRIX_SIZE*WIDTH-1:0]  matrixA,
    input  logic [MATRIX_SIZE*CHUNK_SIZE*WIDTH-1:0]  matrixB,
    output logic [CHUNK_SIZE*CHUNK_SIZE*WIDTH-1:0]   result,
    output logic                                     result_valid,
    output logic                                     busy
);

    localparam int KW = cnt_width(MATRIX_SIZE);
    localparam int RW = cnt_width(CHUNK_SIZE);
    localparam logic [KW-1:0] K_LAST = KW'(MATRIX_SIZE - 1);
    localparam logic [RW-1:0] C_LAST = RW'(CHUNK_SIZE - 1);

    // ID only tags the instance; reject nonsense values at elaboration.
    if (ID < 0) begin : g_id_check
        $error("pim_mac_engine: ID must be non-negative");
    end

    logic [WIDTH-1:0] w_a_in [CHUNK_SIZE][MATRIX_SIZE];
    logic [WIDTH-1:0] w_b_in [MATRIX_SIZE][CHUNK_SIZE];
    logic [WIDTH-1:0] r_a    [CHUNK_SIZE][MATRIX_SIZE];
    logic [WIDTH-1:0] r_b    [MATRIX_SIZE][CHUNK_SIZE];
    logic [WIDTH-1:0] r_res  [CHUNK_SIZE][CHUNK_SIZE];

    mac_state_t       r_state;
    mac_state_t       w_next_state;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_col;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_sum;
    logic             w_last_k;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_capture;

    // Flat bus <-> 2-D element views.
    for (genvar gr = 0; gr < CHUNK_SIZE; gr++) begin : g_a_row
        for (genvar gk = 0; gk < MATRIX_SIZE; gk++) begin : g_a_k
            assign w_a_in[gr][gk] = matrixA[(gr*MATRIX_SIZE+gk)*WIDTH +: WIDTH];
            assign w_b_in[gk][gr] = matrixB[(gk*CHUNK_SIZE+gr)*WIDTH +: WIDTH];
        end
        for (genvar gc = 0; gc < CHUNK_SIZE; gc++) begin : g_res_col
            assign result[(gr*CHUNK_SIZE+gc)*WIDTH +: WIDTH] = r_res[gr][gc];
        end
    end

    assign w_last_k   = (r_k == K_LAST);
    assign w_last_col = (r_col == C_LAST);
    assign w_last_row = (r_row == C_LAST);
    assign w_capture  = (r_state == IDLE) && valid;

    assign busy         = (r_state == COMPUTE);
    assign result_valid = (r_state == DONE);

    pim_mac #(
        .WIDTH (WIDTH)
    ) u_mac (
        .i_acc (r_acc),
        .i_a   (r_a[r_row][r_k]),
        .i_b   (r_b[r_k][r_col]),
        .o_sum (w_sum)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, independent of block order.
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves
        // w_next_state unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (valid) w_next_state = COMPUTE;
            COMPUTE: if (w_last_k && w_last_col && w_last_row) w_next_state = DONE;
            DONE:    if (!valid) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- Operand capture ----------------
    // NOTE: the operand arrays carry no reset: they are always rewritten on
    // capture before being read, so a reset would only cost flop area.
    always_ff @(posedge clk) begin
        if (rst && w_capture) begin
            r_a <= w_a_in;
            r_b <= w_b_in;
        end
    end

    // ---------------- Counters, accumulator, result tile ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_acc <= '0;
            for (int i = 0; i < CHUNK_SIZE; i++)
                for (int j = 0; j < CHUNK_SIZE; j++)
                    r_res[i][j] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                COMPUTE: begin
                    if (w_last_k) begin
                        // Element complete: store it and restart the sum.
                        r_res[r_row][r_col] <= w_sum;
                        r_acc <= '0;
                        r_k   <= '0;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= w_last_row ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + RW'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_pim_mac_engine
// Scoreboard bench for pim_mac_engine (WIDTH=16, M=4, C=2). The stimulus
// process pushes the expected tile and completion cycle for every request;
// an independent monitor pops and compares whenever result_valid rises.
// -----------------------------------------------------------------------------
module tb_pim_mac_engine;
    import pim_mac_engine_pkg::*;

    localparam int W   = 16;
    localparam int M   = 4;
    localparam int C   = 2;
    localparam int AW  = C * M * W;
    localparam int BW  = M * C * W;
    localparam int RSW = C * C * W;
    localparam int LAT = C * C * M;

    typedef struct {
        logic [RSW-1:0] tile;
        int             done_cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           valid;
    logic [AW-1:0]  matrixA;
    logic [BW-1:0]  matrixB;
    logic [RSW-1:0] result;
    logic           result_valid;
    logic           busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_rv = 1'b0;

    pim_mac_engine #(
        .ID          (0),
        .WIDTH       (W),
        .MATRIX_SIZE (M),
        .CHUNK_SIZE  (C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .matrixA      (matrixA),
        .matrixB      (matrixB),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the number of posedges seen; sampled on negedges.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Reference model ----------------
    // Plain matrix product of the chunks, each product cut to 16 bits, then
    // the sum reduced per the accumulation mode.
    function automatic logic [RSW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [RSW-1:0] t;
        longint unsigned s;
        longint unsigned p;
        t = '0;
        for (int r = 0; r < C; r++) begin
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int k = 0; k < M; k++) begin
                    p = longint'(a[(r*M+k)*W +: W]) * longint'(b[(k*C+c)*W +: W]);
                    s += p % 65536;
                end
`ifdef PIM_MAC_SATURATE_EN
                if (s > 65535) s = 65535;
`else
                s = s % 65536;
`endif
                t[(r*C+c)*W +: W] = W'(s);
            end
        end
        return t;
    endfunction

    function automatic logic [AW-1:0] fill_const(input logic [W-1:0] v);
        logic [AW-1:0] x;
        for (int i = 0; i < C*M; i++) x[i*W +: W] = v;
        return x;
    endfunction

    function automatic logic [AW-1:0] rand_vec();
        logic [AW-1:0] x;
        for (int i = 0; i < C*M; i++) begin
            case ($urandom_range(0, 3))
                0:       x[i*W +: W] = W'($urandom_range(0, 15));
                1:       x[i*W +: W] = W'(16'hFF00 | $urandom_range(0, 255));
                default: x[i*W +: W] = W'($urandom);
            endcase
        end
        return x;
    endfunction

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (result_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: result_valid rose with nothing expected, result %h (cyc %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                check("tile", result, e.tile);
                check("done_latency", cyc, e.done_cyc);
                check("busy_in_done", busy, 1'b0);
            end
        end
        prev_rv = result_valid;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic start_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input bit expect_result, output int t0);
        @(negedge clk);
        matrixA = a;
        matrixB = b;
        valid   = 1'b1;
        @(negedge clk);
        t0 = cyc;
        if (expect_result) sb.push_back('{tile: model(a, b), done_cyc: t0 + LAT});
        check("busy_after_capture", busy, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", result_valid, 1'b1);
    endtask

    task automatic finish_op();
        wait_done();
        valid = 1'b0;
        @(negedge clk);
        check("rv_drop", result_valid, 1'b0);
        check("busy_idle", busy, 1'b0);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        logic [AW-1:0] a_id;
        logic [BW-1:0] b_id;
        logic [AW-1:0] a_ff;
        int t0;

        // Reset with valid high: reset wins, nothing is captured.
        rst     = 1'b0;
        valid   = 1'b1;
        matrixA = rand_vec();
        matrixB = rand_vec();
        repeat (2) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_rv", result_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_capture_after_reset", busy, 1'b0);

        // Identity: rows {1,2,3,4},{5,6,7,8} times first two columns of I4.
        for (int r = 0; r < C; r++)
            for (int k = 0; k < M; k++)
                a_id[(r*M+k)*W +: W] = W'(r*M + k + 1);
        for (int k = 0; k < M; k++)
            for (int c = 0; c < C; c++)
                b_id[(k*C+c)*W +: W] = (k == c) ? W'(1) : W'(0);
        start_op(a_id, b_id, 1'b1, t0);
        finish_op();
        check("identity_tile", result, 64'h0006_0005_0002_0001);

        // Inputs changed one cycle after capture must not disturb the tile.
        start_op(a_id, b_id, 1'b1, t0);
        matrixA = fill_const(16'd9);
        matrixB = rand_vec();
        finish_op();
        check("input_change_tile", result, 64'h0006_0005_0002_0001);

        // Handshake: valid held 30 cycles, result held, no second run.
        start_op(rand_vec(), rand_vec(), 1'b1, t0);
        while (cyc < t0 + 30) begin
            @(negedge clk);
            if (cyc >= t0 + LAT) begin
                check("hold_rv", result_valid, 1'b1);
                check("hold_no_restart", busy, 1'b0);
            end
        end
        valid = 1'b0;
        @(negedge clk);
        check("hold_release_rv", result_valid, 1'b0);
        start_op(rand_vec(), rand_vec(), 1'b1, t0);
        finish_op();

        // Overflow: products truncated to zero, then wrap vs saturate.
        start_op(fill_const(16'h0100), fill_const(16'h0100), 1'b1, t0);
        finish_op();
        check("trunc_zero_tile", result, '0);
        a_ff = fill_const(16'h00FF);
        start_op(a_ff, a_ff, 1'b1, t0);
        finish_op();
`ifdef PIM_MAC_SATURATE_EN
        check("ff_elem0", result[W-1:0], 16'hFFFF);
`else
        check("ff_elem0", result[W-1:0], 16'hF804);
`endif

        // Mid-operation reset on cycle 7 of COMPUTE discards the tile.
        start_op(rand_vec(), rand_vec(), 1'b0, t0);
        valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_result", result, '0);
        check("midreset_rv", result_valid, 1'b0);
        check("midreset_busy", busy, 1'b0);
        rst = 1'b1;
        start_op(a_id, b_id, 1'b1, t0);
        finish_op();

        // Randomized traffic.
        for (int n = 0; n < 12; n++) begin
            start_op(rand_vec(), rand_vec(), 1'b1, t0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_op();
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
